ulpb_pwr_seq: RTL and testbench

ULPB_PWR_SEQ -- requirements
Module: ulpb_pwr_seq

---
 rtl/ulpb_pwr_seq_pkg.sv | 47 ++++
 rtl/ulpb_pwr_seq_dom.sv | 116 +++++++++++
 rtl/ulpb_pwr_seq.sv | 44 ++++
 tb/tb_ulpb_pwr_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ulpb_pwr_seq_pkg.sv
// Shared definitions for the ULPB power sequencer: control polarity, domain
// state encoding and the state-to-control decode used by every domain.
package ulpb_pwr_seq_pkg;

  localparam logic IO_HOLD    = 1'b0;
  localparam logic IO_RELEASE = 1'b1;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PWR_UP = 3'd1,
    ST_CLK_UP = 3'd2,
    ST_RST_UP = 3'd3,
    ST_ON     = 3'd4,
    ST_ISO_DN = 3'd5,
    ST_RST_DN = 3'd6,
    ST_CLK_DN = 3'd7
  } dom_state_e;

  typedef struct packed {
    logic pwr;
    logic clk;
    logic rst;
    logic iso;
  } dom_ctrl_t;

  localparam dom_ctrl_t CTRL_ALL_HOLD = '{pwr: IO_HOLD, clk: IO_HOLD, rst: IO_HOLD, iso: IO_HOLD};

  // Each control is released exactly in the states between its wake step and its sleep step.
  function automatic dom_ctrl_t ctrl_for_state(input dom_state_e s);
    dom_ctrl_t c;
    c.pwr = (s != ST_OFF) ? IO_RELEASE : IO_HOLD;
    c.clk = (s inside {ST_CLK_UP, ST_RST_UP, ST_ON, ST_ISO_DN, ST_RST_DN}) ? IO_RELEASE : IO_HOLD;
    c.rst = (s inside {ST_RST_UP, ST_ON, ST_ISO_DN}) ? IO_RELEASE : IO_HOLD;
    c.iso = (s == ST_ON) ? IO_RELEASE : IO_HOLD;
    return c;
  endfunction

  function automatic dom_ctrl_t ctrl_merge(input dom_ctrl_t a, input dom_ctrl_t b);
    dom_ctrl_t c;
    c.pwr = (a.pwr == IO_HOLD || b.pwr == IO_HOLD) ? IO_HOLD : IO_RELEASE;
    c.clk = (a.clk == IO_HOLD || b.clk == IO_HOLD) ? IO_HOLD : IO_RELEASE;
    c.rst = (a.rst == IO_HOLD || b.rst == IO_HOLD) ? IO_HOLD : IO_RELEASE;
    c.iso = (a.iso == IO_HOLD || b.iso == IO_HOLD) ? IO_HOLD : IO_RELEASE;
    return c;
  endfunction

endpackage

// File: rtl/ulpb_pwr_seq_dom.sv
// One power domain: sequencing FSM plus step down-counter. With
// ULPB_PWR_SEQ_NEGEDGE_EN defined, releases are delayed to the following negedge.
//   state     | meaning
//   OFF       | all controls held, waiting for wake
//   PWR_UP    | power released
//   CLK_UP    | clock released
//   RST_UP    | reset released
//   ON        | isolation released, domain awake
//   ISO_DN    | isolation held
//   RST_DN    | reset held
//   CLK_DN    | clock held, power still on
module ulpb_pwr_seq_dom
  import ulpb_pwr_seq_pkg::*;
#(
  parameter int unsigned STEP_CYC  = 2,
  parameter bit          AUTO_WAKE = 1'b1
) (
  input  logic CLKIN,
  input  logic RESETn,
  input  logic i_sleep_req,
  input  logic i_wake_req,
  output logic o_power_on,
  output logic o_release_clk,
  output logic o_release_rst,
  output logic o_release_iso,
  output logic o_dom_on,
  output logic o_busy
);

  localparam int unsigned       CNT_W    = $clog2(STEP_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(STEP_CYC - 1);

  dom_state_e       r_state;
  dom_state_e       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_first;
  dom_ctrl_t        r_ctrl_p;
  logic             r_dom_on;
  dom_ctrl_t        w_ctrl_next;
  dom_ctrl_t        w_ctrl_out;
  logic             w_step_done;
  logic             w_wake;

  assign w_step_done = (r_cnt == '0);
  assign w_wake      = i_wake_req | (r_first & AUTO_WAKE);

  always_ff @(posedge CLKIN or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_first <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_first <= 1'b0;
      if (w_next_state != r_state) begin
        r_cnt <= CNT_LOAD;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Requests are only looked at in OFF and ON; transitional states run to completion.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_OFF:    if (w_wake)      w_next_state = ST_PWR_UP;
      ST_PWR_UP: if (w_step_done) w_next_state = ST_CLK_UP;
      ST_CLK_UP: if (w_step_done) w_next_state = ST_RST_UP;
      ST_RST_UP: if (w_step_done) w_next_state = ST_ON;
      ST_ON:     if (i_sleep_req) w_next_state = ST_ISO_DN;
      ST_ISO_DN: if (w_step_done) w_next_state = ST_RST_DN;
      ST_RST_DN: if (w_step_done) w_next_state = ST_CLK_DN;
      ST_CLK_DN: if (w_step_done) w_next_state = ST_OFF;
      default:                    w_next_state = ST_OFF;
    endcase
  end

  always_comb begin
    w_ctrl_next = ctrl_for_state(w_next_state);
  end

  always_ff @(posedge CLKIN or negedge RESETn) begin
    if (!RESETn) begin
      r_ctrl_p <= CTRL_ALL_HOLD;
      r_dom_on <= 1'b0;
    end else begin
      r_ctrl_p <= w_ctrl_next;
      r_dom_on <= (w_next_state == ST_ON);
    end
  end

`ifdef ULPB_PWR_SEQ_NEGEDGE_EN
  dom_ctrl_t r_ctrl_n;

  always_ff @(negedge CLKIN or negedge RESETn) begin
    if (!RESETn) begin
      r_ctrl_n <= CTRL_ALL_HOLD;
    end else begin
      r_ctrl_n <= r_ctrl_p;
    end
  end

  assign w_ctrl_out = ctrl_merge(r_ctrl_p, r_ctrl_n);
`else
  assign w_ctrl_out = r_ctrl_p;
`endif

  assign o_power_on    = w_ctrl_out.pwr;
  assign o_release_clk = w_ctrl_out.clk;
  assign o_release_rst = w_ctrl_out.rst;
  assign o_release_iso = w_ctrl_out.iso;
  assign o_dom_on      = r_dom_on;
  assign o_busy        = !(r_state inside {ST_OFF, ST_ON});

endmodule

// File: rtl/ulpb_pwr_seq.sv
// ULPB power sequencer top: NUM_DOM independent domain sequencers and the BUSY
// reduction. Optional macro ULPB_PWR_SEQ_NEGEDGE_EN adds half-cycle release delay.
module ulpb_pwr_seq
  import ulpb_pwr_seq_pkg::*;
#(
  parameter int unsigned         NUM_DOM   = 2,
  parameter int unsigned         STEP_CYC  = 2,
  parameter logic [NUM_DOM-1:0]  AUTO_WAKE = '1
) (
  input  logic               CLKIN,
  input  logic               RESETn,
  input  logic [NUM_DOM-1:0] SLEEP_REQ,
  input  logic [NUM_DOM-1:0] WAKE_REQ,
  output logic [NUM_DOM-1:0] POWER_ON,
  output logic [NUM_DOM-1:0] RELEASE_CLK,
  output logic [NUM_DOM-1:0] RELEASE_RST,
  output logic [NUM_DOM-1:0] RELEASE_ISO,
  output logic [NUM_DOM-1:0] DOM_ON,
  output logic               BUSY
);

  logic [NUM_DOM-1:0] w_busy;

  for (genvar g = 0; g < NUM_DOM; g++) begin : g_dom
    ulpb_pwr_seq_dom #(
      .STEP_CYC  (STEP_CYC),
      .AUTO_WAKE (AUTO_WAKE[g])
    ) u_dom (
      .CLKIN         (CLKIN),
      .RESETn        (RESETn),
      .i_sleep_req   (SLEEP_REQ[g]),
      .i_wake_req    (WAKE_REQ[g]),
      .o_power_on    (POWER_ON[g]),
      .o_release_clk (RELEASE_CLK[g]),
      .o_release_rst (RELEASE_RST[g]),
      .o_release_iso (RELEASE_ISO[g]),
      .o_dom_on      (DOM_ON[g]),
      .o_busy        (w_busy[g])
    );
  end

  assign BUSY = |w_busy;

endmodule

// File: tb/tb_ulpb_pwr_seq.sv
// Scoreboard bench for ulpb_pwr_seq: a timeline model predicts each cycle's
// controls from how many step periods have elapsed since a sequence started.
module tb_ulpb_pwr_seq;
  import ulpb_pwr_seq_pkg::*;

  localparam int ND   = 2;
  localparam int STEP = 3;
  localparam logic [ND-1:0] AW = 2'b01;

  logic          CLKIN = 1'b0;
  logic          RESETn = 1'b0;
  logic [ND-1:0] SLEEP_REQ = '0;
  logic [ND-1:0] WAKE_REQ = '0;
  logic [ND-1:0] POWER_ON, RELEASE_CLK, RELEASE_RST, RELEASE_ISO, DOM_ON;
  logic          BUSY;

  ulpb_pwr_seq #(.NUM_DOM(ND), .STEP_CYC(STEP), .AUTO_WAKE(AW)) dut (
    .CLKIN(CLKIN), .RESETn(RESETn), .SLEEP_REQ(SLEEP_REQ), .WAKE_REQ(WAKE_REQ),
    .POWER_ON(POWER_ON), .RELEASE_CLK(RELEASE_CLK), .RELEASE_RST(RELEASE_RST),
    .RELEASE_ISO(RELEASE_ISO), .DOM_ON(DOM_ON), .BUSY(BUSY)
  );

  always #5 CLKIN = ~CLKIN;

  typedef struct {
    logic [ND-1:0] pwr, clk, rst, iso, on;
    logic          busy;
    int            edge_n;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Model: mode 0=off, 1=waking, 2=on, 3=sleeping; start = edge the sequence began.
  int mode[ND];
  int start[ND];
  int n_edge;
  bit first;

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      mode[d] = 0;
      start[d] = 0;
    end
    n_edge = 0;
    first = 1'b1;
    sb_q.delete();
  endtask

  task automatic chk(input string name, input int edge_n, input logic [ND-1:0] act, input logic [ND-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %b expected %b", name, edge_n, act, exp);
    end
  endtask

  // Reference model, evaluated at every posedge while out of reset.
  initial begin
    exp_t e;
    int el, m;
    forever begin
      @(posedge CLKIN);
      if (RESETn) begin
        n_edge++;
        e.pwr = '0; e.clk = '0; e.rst = '0; e.iso = '0; e.on = '0; e.busy = 1'b0;
        e.edge_n = n_edge;
        for (int d = 0; d < ND; d++) begin
          el = n_edge - start[d];
          case (mode[d])
            0: if (WAKE_REQ[d] || (first && AW[d])) begin mode[d] = 1; start[d] = n_edge; end
            2: if (SLEEP_REQ[d]) begin mode[d] = 3; start[d] = n_edge; end
            1: if (el >= 3 * STEP) mode[d] = 2;
            3: if (el >= 3 * STEP) mode[d] = 0;
            default: mode[d] = 0;
          endcase
          el = n_edge - start[d];
          case (mode[d])
            1:       m = (1 << (el / STEP + 1)) - 1;       // released from power upward
            2:       m = 15;
            3:       m = (1 << (3 - el / STEP)) - 1;       // held from isolation downward
            default: m = 0;
          endcase
          e.pwr[d] = m[0] ? IO_RELEASE : IO_HOLD;
          e.clk[d] = m[1] ? IO_RELEASE : IO_HOLD;
          e.rst[d] = m[2] ? IO_RELEASE : IO_HOLD;
          e.iso[d] = m[3] ? IO_RELEASE : IO_HOLD;
          e.on[d]  = (mode[d] == 2);
          if (mode[d] == 1 || mode[d] == 3) e.busy = 1'b1;
        end
        first = 1'b0;
        sb_q.push_back(e);
      end
    end
  end

  // Monitor: samples late in the cycle, after any negedge release has landed.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLKIN);
      #8;
      if (RESETn && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("power_on",    e.edge_n, POWER_ON,    e.pwr);
        chk("release_clk", e.edge_n, RELEASE_CLK, e.clk);
        chk("release_rst", e.edge_n, RELEASE_RST, e.rst);
        chk("release_iso", e.edge_n, RELEASE_ISO, e.iso);
        chk("dom_on",      e.edge_n, DOM_ON,      e.on);
        chk("busy",        e.edge_n, {{(ND-1){1'b0}}, BUSY}, {{(ND-1){1'b0}}, e.busy});
      end
    end
  end

  task automatic drive(input logic [ND-1:0] s, input logic [ND-1:0] w);
    @(posedge CLKIN);
    #2;
    SLEEP_REQ = s;
    WAKE_REQ  = w;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive('0, '0);
  endtask

  task automatic random_phase(input int cycles);
    logic [ND-1:0] s, w;
    for (int i = 0; i < cycles; i++) begin
      for (int d = 0; d < ND; d++) begin
        s[d] = ($urandom_range(0, 5) == 0);
        w[d] = ($urandom_range(0, 5) == 0);
      end
      drive(s, w);
    end
  endtask

  task automatic reset_release();
    @(posedge CLKIN);
    #2;
    RESETn = 1'b1;
  endtask

  initial begin
    model_reset();
    RESETn = 1'b0;
    repeat (3) @(posedge CLKIN);
    chk("reset_power_on", 0, POWER_ON, {ND{IO_HOLD}});
    chk("reset_dom_on",   0, DOM_ON,   '0);
    reset_release();

    // Auto-wake of dom0 only, then a sleep pulse with a dom1 wake during it.
    idle(14);
    drive(2'b01, 2'b00);
    idle(5);
    drive(2'b00, 2'b10);
    idle(20);

    // Both requests high: ON domains go to sleep, OFF domains wake.
    for (int i = 0; i < 40; i++) drive(2'b11, 2'b11);
    idle(25);

    random_phase(400);

    // Reset during the wake sequence, checked immediately, then a fresh auto-wake.
    idle(25);
    SLEEP_REQ = '0;
    WAKE_REQ  = '0;
    RESETn = 1'b0;
    model_reset();
    repeat (2) @(posedge CLKIN);
    reset_release();
    repeat (5) @(posedge CLKIN);
    #3;
    RESETn = 1'b0;
    model_reset();
    #1;
    chk("async_power_on",    5, POWER_ON,    {ND{IO_HOLD}});
    chk("async_release_clk", 5, RELEASE_CLK, {ND{IO_HOLD}});
    chk("async_release_rst", 5, RELEASE_RST, {ND{IO_HOLD}});
    chk("async_release_iso", 5, RELEASE_ISO, {ND{IO_HOLD}});
    chk("async_dom_on",      5, DOM_ON,      '0);
    chk("async_busy",        5, {{(ND-1){1'b0}}, BUSY}, '0);
    #2;
    RESETn = 1'b1;
    idle(14);
    random_phase(200);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
